fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Instruction word presented while nothing valid sits at the queue head.
  localparam logic [31:0] NOP = 32'h0;

  // Prefetch queue entry: fetch address and the instruction word read from it.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with push, pop, flush and an occupancy count.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & (~full | do_pop);

  // Pointer and count update; flush discards everything including a same-cycle push.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) mem_q[wr_q] <= push_data;
  end

  assign head_data = mem_q[rd_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

  // The upstream credit scheme must never push into a full queue without a pop.
  overflow_chk: assert property (@(posedge clock) disable iff (reset)
    !(push && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// capture into a prefetch queue, and redirect flush with stale-response drop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [CW:0]     in_use;
  logic            q_empty;
  logic            credit_ok;
  logic            acked;
  logic            rsp;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;

  // Requests in flight plus queued entries may never exceed the queue depth.
  assign in_use    = {1'b0, count} + {1'b0, outst_q};
  assign credit_ok = in_use < (CW + 1)'(DEPTH);

  assign imem_req  = credit_ok & ~redirect & ~reset;
  assign imem_addr = fetch_pc_q;

  assign acked = imem_req & imem_ack;
  assign rsp   = imem_rvalid & ~reset;
  assign push  = rsp & (drop_q == '0) & ~redirect;
  assign pop   = if_valid & ~id_stall & ~redirect;

  // rsp_pc tracks the address of the next response that will be kept, so
  // responses carry no address of their own.
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata};

  // Next-state for fetch PC, response PC and the in-flight/drop counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(acked) - CW'(rsp);
    if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
    if (push) rsp_pc_d = rsp_pc_q + XLEN'(4);
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path,
      // which also covers drops pending from an earlier redirect.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_d     = outst_d;
    end else if (acked) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + 32)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_entry),
    .count     (count),
    .empty     (q_empty)
  );

  assign if_valid = ~q_empty;
  assign if_instr = if_valid ? head_entry.instr : NOP;
  assign if_pc    = if_valid ? head_entry.pc : '0;
  assign if_pc4   = if_valid ? head_entry.pc + XLEN'(4) : '0;

  rvalid_chk: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid |-> (outst_q != '0));

  drop_chk: assert property (@(posedge clock) disable iff (reset)
    drop_q <= outst_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, imem_req, imem_ack, imem_rvalid, redirect, id_stall, if_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc, if_pc4;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
  );

  logic        w_reset, w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
  logic        w_done = 1'b0;

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(WPC)) dut_wrap (
    .clock(clock), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .id_stall(1'b0),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_pc4(w_pc4)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
    bit          stale;
  } rsp_t;

  rsp_t         pend[$];
  fetch_entry_t sb[$];
  int unsigned  errors = 0;
  int unsigned  checks = 0;
  int unsigned  cyc = 0;
  int unsigned  last_ready = 0;
  logic [31:0]  model_addr;
  logic [31:0]  exp_pc;
  logic         prev_rst = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive inputs at negedge, check request side at +1,
  // advance the reference model at +3 (after the monitor at +2).
  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic stall, input logic ack, input int unsigned lat);
    logic        rv;
    logic        exp_req;
    int unsigned rdy;
    @(negedge clock);
    rv = !rst && pend.size() > 0 && pend[0].ready <= cyc;
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    id_stall    = stall;
    imem_ack    = ack;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    exp_req = !rst && !redir && (sb.size() + pend.size() < DEPTH);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("imem_addr", imem_addr, model_addr);
    if (rst && prev_rst) begin
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_pc4", if_pc4, 32'h0);
    end
    #2;
    if (rst) begin
      pend.delete();
      sb.delete();
      model_addr = RPC;
      exp_pc     = RPC;
      last_ready = 0;
    end else begin
      if (rv) begin
        if (!pend[0].stale && !redir) begin
          sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
          exp_pc += 32'd4;
        end
        void'(pend.pop_front());
      end
      if (redir) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        sb.delete();
        model_addr = rpc;
        exp_pc     = rpc;
      end else if (exp_req && ack) begin
        rdy = cyc + lat;
        if (rdy <= last_ready) rdy = last_ready + 1;
        last_ready = rdy;
        pend.push_back('{addr: model_addr, ready: rdy, stale: 1'b0});
        model_addr += 32'd4;
      end
    end
    prev_rst = rst;
    cyc++;
  endtask

  // Monitor: compare the queue head against the scoreboard whenever it is consumed.
  always begin
    fetch_entry_t e;
    @(negedge clock);
    #2;
    check("if_valid", 32'(if_valid), 32'(sb.size() != 0));
    if (if_valid && !id_stall && !redirect && !reset && sb.size() != 0) begin
      e = sb.pop_front();
      check("if_pc", if_pc, e.pc);
      check("if_instr", if_instr, e.instr);
      check("if_pc4", if_pc4, e.pc + 32'd4);
    end
  end

  // Wrap-around instance: RESET_PC near the top of the address space.
  initial begin
    logic [31:0] prev_a;
    logic [31:0] e;
    w_reset  = 1'b1;
    w_rvalid = 1'b0;
    w_rdata  = 32'h0;
    prev_a   = 32'h0;
    repeat (2) @(negedge clock);
    w_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w_rvalid = (k > 0);
      w_rdata  = mem_word(prev_a);
      #4;
      if (k < 3) check("wrap_addr", w_addr, WPC + 32'(4 * k));
      if (k >= 2 && k <= 4) begin
        e = WPC + 32'(4 * (k - 2));
        check("wrap_valid", 32'(w_valid), 32'h1);
        check("wrap_pc", w_pc, e);
        check("wrap_pc4", w_pc4, e + 32'd4);
        check("wrap_instr", w_instr, mem_word(e));
      end
      prev_a = w_addr;
      @(negedge clock);
    end
    w_done = 1'b1;
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_addr = RPC;
    exp_pc     = RPC;

    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Zero-wait memory, no stalls.
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1, 1);
    // Long decode stall fills the queue and stops requests.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);
    // Redirect with a full queue, an attempted pop and ack.
    step(0, 1, 32'h200, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 1);
    // Three slow requests in flight, then redirect to 0x100.
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 4);
    step(0, 1, 32'h100, 0, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 1);
    // Address wrap through redirect.
    step(0, 1, 32'hFFFF_FFF0, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1);
    // Reset mid-stream with entries queued and requests outstanding.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 3);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        step(1, 0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1);
        step(1, 0, 0, 0, 0, 1);
      end else begin
        step(0, $urandom_range(99) < 6, $urandom & 32'hFFFF_FFFC,
             $urandom_range(99) < 30, $urandom_range(99) < 60, $urandom_range(4, 1));
      end
    end
    for (int i = 0; i < 200 && !w_done; i++) @(negedge clock);
    check("wrap_done", 32'(w_done), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
